speed_test_axil_master: RTL and testbench

Single-outstanding AXI4-Lite initiator that turns simple command/response handshakes into AXI4-Lite read or write transactions. It sits between the host-side test sequencer (or bench) and the speed test controller's AXI4-Lite register port. It programs test duration and port configs, issues start, polls busy, and collects port results. A per-transaction timeout converts a hung slave into a reported error instead of a deadlock.

---
 rtl/tester_common.sv | 5 +
 rtl/speed_test_axil_master.sv | 155 +++++++++++++++
 tb/tb_speed_test_axil_master.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/tester_common.sv
// tester_common: shared types for the speed test AXI4-Lite initiator and its peers
package tester_common;
  typedef enum logic [1:0] {OKAY = 2'd0, EXOKAY = 2'd1, SLVERR = 2'd2, DECERR = 2'd3} axil_resp_t;
  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RESP, DEAD} mst_state_e;
endpackage

// File: rtl/speed_test_axil_master.sv
// speed_test_axil_master: single-outstanding AXI4-Lite initiator with per-transaction timeout
module speed_test_axil_master
  import tester_common::*;
#(
  parameter int ADDR_WIDTH     = 9,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic                    rsp_timeout,
  output logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]              M_AXI_AWPROT,
  output logic                    M_AXI_AWVALID,
  input  logic                    M_AXI_AWREADY,
  output logic [DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                    M_AXI_WVALID,
  input  logic                    M_AXI_WREADY,
  input  logic [1:0]              M_AXI_BRESP,
  input  logic                    M_AXI_BVALID,
  output logic                    M_AXI_BREADY,
  output logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]              M_AXI_ARPROT,
  output logic                    M_AXI_ARVALID,
  input  logic                    M_AXI_ARREADY,
  input  logic [DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]              M_AXI_RRESP,
  input  logic                    M_AXI_RVALID,
  output logic                    M_AXI_RREADY
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  mst_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic awv_q, awv_d, wv_q, wv_d, arv_q, arv_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
  logic rvld_q, rvld_d, tmo_q, tmo_d;
  logic [1:0] resp_q, resp_d;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, aw_done, w_done, expired;
  assign cmd_ready     = state_q == IDLE;
  assign M_AXI_BREADY  = state_q == WR_REQ || state_q == WR_RESP;
  assign M_AXI_RREADY  = state_q == RD_REQ || state_q == RD_RESP;
  assign M_AXI_AWPROT  = '0;
  assign M_AXI_ARPROT  = '0;
  assign M_AXI_AWVALID = awv_q;
  assign M_AXI_WVALID  = wv_q;
  assign M_AXI_ARVALID = arv_q;
  assign M_AXI_AWADDR  = awaddr_q;
  assign M_AXI_ARADDR  = araddr_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign rsp_valid     = rvld_q;
  assign rsp_rdata     = rdata_q;
  assign rsp_resp      = resp_q;
  assign rsp_timeout   = tmo_q;
  assign aw_hs   = awv_q && M_AXI_AWREADY;
  assign w_hs    = wv_q && M_AXI_WREADY;
  assign ar_hs   = arv_q && M_AXI_ARREADY;
  assign b_hs    = M_AXI_BVALID && M_AXI_BREADY;
  assign r_hs    = M_AXI_RVALID && M_AXI_RREADY;
  assign aw_done = !awv_q || aw_hs;
  assign w_done  = !wv_q || w_hs;
  assign expired = cnt_q == CW'(TIMEOUT_CYCLES - 1);
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    awv_d    = awv_q && !aw_hs;
    wv_d     = wv_q && !w_hs;
    arv_d    = arv_q && !ar_hs;
    awaddr_d = awaddr_q;
    araddr_d = araddr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    rvld_d   = rvld_q;
    rdata_d  = rdata_q;
    resp_d   = resp_q;
    tmo_d    = tmo_q;
    case (state_q)
      IDLE: if (cmd_valid) begin
        state_d  = cmd_write ? WR_REQ : RD_REQ;
        cnt_d    = '0;
        awv_d    = cmd_write;
        wv_d     = cmd_write;
        arv_d    = !cmd_write;
        awaddr_d = cmd_addr;
        araddr_d = cmd_addr;
        wdata_d  = cmd_wdata;
        wstrb_d  = cmd_wstrb;
      end
      WR_REQ, WR_RESP, RD_REQ, RD_RESP: begin
        cnt_d = cnt_q + CW'(1);
        // a B/R handshake on the expiry cycle still reports the real response
        if (b_hs || r_hs || expired) begin
          state_d = RESP;
          awv_d   = 1'b0;
          wv_d    = 1'b0;
          arv_d   = 1'b0;
          rvld_d  = 1'b1;
          tmo_d   = !(b_hs || r_hs);
          rdata_d = r_hs ? M_AXI_RDATA : '0;
          resp_d  = r_hs ? M_AXI_RRESP : b_hs ? M_AXI_BRESP : SLVERR;
        end else if (state_q == WR_REQ && aw_done && w_done) state_d = WR_RESP;
        else if (state_q == RD_REQ && ar_hs) state_d = RD_RESP;
      end
      RESP: if (rsp_ready) begin
        rvld_d  = 1'b0;
        state_d = tmo_q ? DEAD : IDLE;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      awv_q    <= 1'b0;
      wv_q     <= 1'b0;
      arv_q    <= 1'b0;
      awaddr_q <= '0;
      araddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      rvld_q   <= 1'b0;
      rdata_q  <= '0;
      resp_q   <= '0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      awv_q    <= awv_d;
      wv_q     <= wv_d;
      arv_q    <= arv_d;
      awaddr_q <= awaddr_d;
      araddr_q <= araddr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      rvld_q   <= rvld_d;
      rdata_q  <= rdata_d;
      resp_q   <= resp_d;
      tmo_q    <= tmo_d;
    end
  end
endmodule

// File: tb/tb_speed_test_axil_master.sv
// tb_speed_test_axil_master: randomized host commands against a behavioural AXI4-Lite slave and memory model
module tb_speed_test_axil_master;
  logic clk, rst;
  logic cmd_valid, cmd_ready, cmd_write, rsp_valid, rsp_ready, rsp_timeout;
  logic [8:0] cmd_addr, M_AXI_AWADDR, M_AXI_ARADDR;
  logic [31:0] cmd_wdata, rsp_rdata, M_AXI_WDATA, M_AXI_RDATA;
  logic [3:0] cmd_wstrb, M_AXI_WSTRB;
  logic [1:0] rsp_resp, M_AXI_BRESP, M_AXI_RRESP;
  logic [2:0] M_AXI_AWPROT, M_AXI_ARPROT;
  logic M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY, M_AXI_BVALID, M_AXI_BREADY;
  logic M_AXI_ARVALID, M_AXI_ARREADY, M_AXI_RVALID, M_AXI_RREADY;
  int n_chk = 0, n_err = 0;
  int mode = 0;
  bit b_early = 0;
  logic [31:0] smem [128];
  logic [31:0] rmem [128];
  logic [8:0] cap_awaddr, cap_araddr;
  logic [31:0] cap_wdata;
  logic [3:0] cap_wstrb;
  int n_aw = 0, n_w = 0, n_ar = 0, n_b = 0;
  bit aw_pend, w_pend, ar_pend, b_fire, r_fire;
  int aw_w, w_w, b_w, ar_w, r_w;

  speed_test_axil_master #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .rsp_timeout(rsp_timeout),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT), .M_AXI_AWVALID(M_AXI_AWVALID),
    .M_AXI_AWREADY(M_AXI_AWREADY), .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY), .M_AXI_BRESP(M_AXI_BRESP),
    .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY), .M_AXI_ARADDR(M_AXI_ARADDR),
    .M_AXI_ARPROT(M_AXI_ARPROT), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RVALID(M_AXI_RVALID),
    .M_AXI_RREADY(M_AXI_RREADY)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // mode 0: random ready/valid with at most 3 wait cycles; 1: always immediate; 2: never
  function automatic bit go(input int w);
    return mode == 1 ? 1'b1 : mode == 2 ? 1'b0 : (w >= 3 || $urandom_range(0, 1) == 1);
  endfunction

  // slave decides at the negedge what happens on the next posedge
  initial begin
    M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_ARREADY = 0;
    M_AXI_BVALID = 0; M_AXI_BRESP = 0; M_AXI_RVALID = 0; M_AXI_RDATA = 0; M_AXI_RRESP = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_ARREADY = 0; M_AXI_BVALID = 0; M_AXI_RVALID = 0;
        aw_pend = 0; w_pend = 0; ar_pend = 0; b_fire = 0; r_fire = 0;
        aw_w = 0; w_w = 0; b_w = 0; ar_w = 0; r_w = 0;
      end else begin
        if (b_fire) M_AXI_BVALID = 0;
        if (r_fire) M_AXI_RVALID = 0;
        M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_ARREADY = 0;
        if (M_AXI_AWVALID && !aw_pend) begin
          if (go(aw_w)) begin
            M_AXI_AWREADY = 1; aw_pend = 1; cap_awaddr = M_AXI_AWADDR; n_aw++; aw_w = 0;
          end else aw_w++;
        end
        if (M_AXI_WVALID && !w_pend) begin
          if (go(w_w)) begin
            M_AXI_WREADY = 1; w_pend = 1; cap_wdata = M_AXI_WDATA; cap_wstrb = M_AXI_WSTRB; n_w++; w_w = 0;
          end else w_w++;
        end
        if (aw_pend && w_pend && !M_AXI_BVALID && (b_early || !(M_AXI_AWREADY || M_AXI_WREADY))) begin
          if (b_early || go(b_w)) begin
            if (!cap_awaddr[8])
              for (int b = 0; b < 4; b++)
                if (cap_wstrb[b]) smem[cap_awaddr[8:2]][8*b+:8] = cap_wdata[8*b+:8];
            M_AXI_BVALID = 1; M_AXI_BRESP = cap_awaddr[8] ? 2'b10 : 2'b00;
            aw_pend = 0; w_pend = 0; b_w = 0; n_b++;
          end else b_w++;
        end
        if (M_AXI_ARVALID && !ar_pend) begin
          if (go(ar_w)) begin
            M_AXI_ARREADY = 1; ar_pend = 1; cap_araddr = M_AXI_ARADDR; n_ar++; ar_w = 0;
          end else ar_w++;
        end
        if (ar_pend && !M_AXI_RVALID && !M_AXI_ARREADY) begin
          if (go(r_w)) begin
            M_AXI_RVALID = 1; M_AXI_RRESP = cap_araddr[8] ? 2'b10 : 2'b00;
            M_AXI_RDATA = cap_araddr[8] ? 32'h0 : smem[cap_araddr[8:2]];
            ar_pend = 0; r_w = 0;
          end else r_w++;
        end
        b_fire = M_AXI_BVALID && M_AXI_BREADY;
        r_fire = M_AXI_RVALID && M_AXI_RREADY;
      end
    end
  end

  // issue one command from a negedge; lat = posedges from acceptance to rsp_valid
  task automatic do_cmd(input bit wr, input logic [8:0] a, input logic [31:0] d, input logic [3:0] s,
                        input int hold, output logic [31:0] rd, output logic [1:0] rr, output bit to,
                        output int lat);
    int w;
    bit stab, lo;
    cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1;
    w = 0;
    while (!cmd_ready && w < 50) begin @(negedge clk); w++; end
    check("cmd_accept", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 0;
    lat = 0;
    while (!rsp_valid && lat < 40) begin @(negedge clk); lat++; end
    check("rsp_seen", rsp_valid, 1);
    rd = rsp_rdata; rr = rsp_resp; to = rsp_timeout;
    stab = 1; lo = !cmd_ready;
    repeat (hold) begin
      @(negedge clk);
      stab &= rsp_valid && rsp_rdata == rd && rsp_resp == rr && rsp_timeout == to;
      lo &= !cmd_ready;
    end
    check("rsp_stable", stab, 1);
    check("cmd_ready_lo", lo, 1);
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    check("rsp_drop", rsp_valid, 0);
  endtask

  // command plus all reference-model checks for a transaction that must complete normally
  task automatic run_cmd(input bit wr, input logic [8:0] a, input logic [31:0] d, input logic [3:0] s,
                         input int hold, output int lat);
    logic [31:0] rd;
    logic [1:0] rr;
    bit to;
    int na, nw, nr, nb;
    na = n_aw; nw = n_w; nr = n_ar; nb = n_b;
    do_cmd(wr, a, d, s, hold, rd, rr, to, lat);
    check("resp", rr, a[8] ? 2'b10 : 2'b00);
    check("timeout_flag", to, 0);
    check("idle_after", cmd_ready, 1);
    check("lat_bound", lat < 16, 1);
    if (wr) begin
      check("aw_count", n_aw - na, 1);
      check("w_count", n_w - nw, 1);
      check("b_count", n_b - nb, 1);
      check("awaddr", cap_awaddr, a);
      check("wdata", cap_wdata, d);
      check("wstrb", cap_wstrb, s);
      check("wr_rdata", rd, 0);
      if (!a[8])
        for (int b = 0; b < 4; b++)
          if (s[b]) rmem[a[8:2]][8*b+:8] = d[8*b+:8];
    end else begin
      check("ar_count", n_ar - nr, 1);
      check("araddr", cap_araddr, a);
      check("rd_rdata", rd, a[8] ? 32'h0 : rmem[a[8:2]]);
    end
  endtask

  initial begin
    bit wr, ok, to;
    int r, lat, nb;
    logic [8:0] a;
    logic [31:0] d, rd;
    logic [3:0] s;
    logic [1:0] rr;
    cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0; rsp_ready = 0;
    for (int i = 0; i < 128; i++) begin smem[i] = 0; rmem[i] = 0; end
    rst = 0;
    #1 rst = 1;
    #2;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_rsp", {rsp_valid, rsp_timeout, rsp_resp, rsp_rdata}, 0);
    check("rst_axi_ctl", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_BREADY, M_AXI_RREADY}, 0);
    check("rst_axi_data", {M_AXI_AWADDR, M_AXI_ARADDR, M_AXI_WDATA, M_AXI_WSTRB}, 0);
    check("prot", {M_AXI_AWPROT, M_AXI_ARPROT}, 0);
    @(negedge clk); @(negedge clk);
    rst = 0;
    @(negedge clk);
    mode = 1;
    run_cmd(1, 9'h008, 32'h0000_1000, 4'hF, 0, lat);
    check("wr_lat_fast", lat, 2);
    run_cmd(0, 9'h008, 0, 0, 10, lat);
    check("rd_lat_fast", lat, 2);
    b_early = 1;
    nb = n_b;
    run_cmd(1, 9'h004, 32'hCAFE_F00D, 4'h5, 1, lat);
    check("early_b_lat", lat, 1);
    ok = 1;
    repeat (4) begin @(negedge clk); ok &= !rsp_valid; end
    check("single_rsp", ok && n_b - nb == 1, 1);
    b_early = 0;
    mode = 0;
    for (int i = 0; i < 80; i++) begin
      wr = 1'($urandom_range(0, 1));
      r = int'($urandom_range(0, 7));
      a = r < 4 ? 9'(r * 4) : 9'(9'h100 + (r - 4) * 4);
      d = $urandom;
      s = 4'($urandom_range(1, 15));
      run_cmd(wr, a, d, s, int'($urandom_range(0, 3)), lat);
    end
    mode = 2;
    cmd_write = 1; cmd_addr = 9'h00C; cmd_wdata = 32'h1234_5678; cmd_wstrb = 4'hF; cmd_valid = 1;
    @(negedge clk);
    cmd_valid = 0;
    check("pre_rst_valid", {M_AXI_AWVALID, M_AXI_WVALID}, 2'b11);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst = 1;
    #1;
    check("async_rst_valid", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY}, 0);
    @(negedge clk); @(negedge clk);
    rst = 0;
    @(negedge clk);
    check("post_rst_ready", cmd_ready, 1);
    do_cmd(0, 9'h000, 0, 0, 2, rd, rr, to, lat);
    check("tmo_lat", lat, 16);
    check("tmo_resp", rr, 2'b10);
    check("tmo_flag", to, 1);
    check("tmo_arvalid", M_AXI_ARVALID, 0);
    cmd_write = 0; cmd_addr = 0; cmd_valid = 1;
    ok = 1;
    repeat (6) begin @(negedge clk); ok &= !cmd_ready && !M_AXI_ARVALID && !M_AXI_AWVALID; end
    check("dead_hold", ok, 1);
    cmd_valid = 0;
    rst = 1;
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    check("dead_rst_ready", cmd_ready, 1);
    mode = 1;
    run_cmd(0, 9'h008, 0, 0, 0, lat);
    check("recover_lat", lat, 2);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
